if_id_pipe_stage: RTL and testbench
===================================

// Module: if_id_pipe_stage
// PURPOSE
//  Parametrised IF->ID pipeline register with valid/ready handshake, stall, flush and an optional skid buffer.
//  Carries fetched instruction, PC+4 and a fetch-fault flag from the IF stage into ID.
//  Inserts a NOP bubble on flush. Counts stall cycles for perf monitoring.
//  Sits between the fetch unit and the decoder in the 5-stage core.
// PARAMETERS
//  ILEN     32   instruction width
//  XLEN     32   PC width
//  NOP_INST 0    instruction value presented when the stage holds no valid entry
//  SKID     1    1: 2-entry skid buffer, registered in_ready; 0: single register, combinational in_ready
//  CNT_W    16   stall-counter width
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  flush        in   1     squash all held entries (branch/jump redirect)
//  if_valid     in   1     IF presents an entry
//  if_ready     out  1     stage can accept an entry this cycle
//  if_inst      in   ILEN  fetched instruction
//  if_pc_4      in   XLEN  PC+4 of fetched instruction
//  if_fault     in   1     fetch fault on this entry
//  id_valid     out  1     entry valid toward ID
//  id_ready     in   1     ID accepts (0 = ID stall)
//  id_inst      out  ILEN  instruction (NOP_INST when !id_valid)
//  id_pc_4      out  XLEN  PC+4 (0 when !id_valid)
//  id_fault     out  1     fault flag (0 when !id_valid)
//  stall_cnt    out  CNT_W cycles with id_valid && !id_ready
// BEHAVIOUR
//  - Reset: id_valid=0, id_inst=NOP_INST, id_pc_4=0, id_fault=0, stall_cnt=0, skid empty; if_ready=1 after reset deasserts.
//  - Transfer in: if_valid && if_ready at posedge. Transfer out: id_valid && id_ready at posedge.
//  - Latency 1 cycle: an accepted entry appears on id_* the following cycle when the main register is free.
//  - Main register (M) holds the entry shown on id_*. id_* payload registered; no comb path if_*->id_*.
//  - SKID=0: if_ready = !M.valid || id_ready (combinational). M loads on in-transfer; clears on out-transfer without in-transfer.
//  - SKID=1: if_ready = !S.valid (registered). In-transfer while M full and no out-transfer -> entry goes to skid S.
//    Out-transfer with S valid -> M<=S, S cleared (S drained before any new input; order preserved).
//    Out- and in-transfer same cycle, S empty -> M<=new entry.
//  - Entries never dropped, duplicated or reordered; payload stable while id_valid && !id_ready.
//  - flush: priority over all; at posedge M and S invalidated, id_inst<=NOP_INST, id_pc_4<=0, id_fault<=0.
//    An in-transfer coincident with flush is discarded. if_ready=1 the cycle after flush.
//  - stall_cnt increments when id_valid && !id_ready && !flush; saturates at all-ones (no wrap). Cleared only by rst.
//  - rst asserted mid-operation: all state to reset values immediately (async), held entries lost.
// STRUCTURE
//  - Shared package core_pkg: NOP_INST default, XLEN/ILEN defaults, if_id_entry_t {inst, pc_4, fault, valid}.
//  - One sub-module natural: pipe_entry_reg (entry register with load/clear, async reset), instantiated for M and S.
//  - S and its muxing generated only when SKID=1.
// TESTING
//  1. rst pulse mid-stream with M,S full -> same cycle id_valid=0, id_inst=NOP_INST, stall_cnt=0.
//  2. Streaming, id_ready=1: inst 0x20080001..0x20080004 with pc_4 0x4..0x10 -> appear on id_* one cycle later, back-to-back.
//  3. SKID=1: id_ready=0 for 3 cycles while IF streams A,B -> A held, B in S, if_ready=0; release -> A then B, no loss.
//  4. flush while M,S full and if_valid=1 (C) -> next cycle id_valid=0, id_inst=NOP_INST, C never appears, if_ready=1.
//  5. id_ready=0 with valid entry for 2^CNT_W+5 cycles (CNT_W=4) -> stall_cnt saturates at 15.
//  6. SKID=0: id_ready=0 with M full -> if_ready=0 same cycle; id_ready=1 -> if_ready=1 combinationally, simultaneous swap.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the IF/ID boundary of the 5-stage core.
// Defaults are overridable per instance through module parameters.
package core_pkg;

    localparam int          ILEN_DEF     = 32;
    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [ILEN_DEF-1:0] inst;
        logic [XLEN_DEF-1:0] pc_4;
        logic                fault;
        logic                valid;
    } if_id_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One IF/ID entry register: valid bit plus payload, cleared to a NOP bubble.
// A clear takes priority over a load in the same cycle.
module pipe_entry_reg
    import core_pkg::*;
#(
    parameter int              ILEN     = ILEN_DEF,
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [ILEN-1:0] NOP_INST = ILEN'(NOP_INST_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [ILEN-1:0] next_inst,
    input  logic [XLEN-1:0] next_pc_4,
    input  logic            next_fault,
    output logic            valid,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] pc_4,
    output logic            fault
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc_4  <= '0;
            fault <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc_4  <= '0;
            fault <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= next_inst;
            pc_4  <= next_pc_4;
            fault <= next_fault;
        end
    end

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF->ID pipeline register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and a saturating ID-stall counter.
module if_id_pipe_stage
    import core_pkg::*;
#(
    parameter int              ILEN     = ILEN_DEF,
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [ILEN-1:0] NOP_INST = ILEN'(NOP_INST_DEF),
    parameter int              SKID     = 1,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [ILEN-1:0]  if_inst,
    input  logic [XLEN-1:0]  if_pc_4,
    input  logic             if_fault,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [ILEN-1:0]  id_inst,
    output logic [XLEN-1:0]  id_pc_4,
    output logic             id_fault,
    output logic [CNT_W-1:0] stall_cnt
);

    logic            in_xfer;
    logic            out_xfer;
    logic            m_load;
    logic            m_clear;
    logic [ILEN-1:0] m_next_inst;
    logic [XLEN-1:0] m_next_pc_4;
    logic            m_next_fault;

    // Input accepted during a flush is squashed along with the held entries.
    assign in_xfer  = if_valid && if_ready && !flush;
    assign out_xfer = id_valid && id_ready;

    pipe_entry_reg #(
        .ILEN     (ILEN),
        .XLEN     (XLEN),
        .NOP_INST (NOP_INST)
    ) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (m_load),
        .clear      (m_clear),
        .next_inst  (m_next_inst),
        .next_pc_4  (m_next_pc_4),
        .next_fault (m_next_fault),
        .valid      (id_valid),
        .inst       (id_inst),
        .pc_4       (id_pc_4),
        .fault      (id_fault)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic            s_valid;
            logic [ILEN-1:0] s_inst;
            logic [XLEN-1:0] s_pc_4;
            logic            s_fault;
            logic            s_load;
            logic            s_clear;
            logic            take_skid;

            // if_ready is a pure register output, so IF timing never sees id_ready.
            assign if_ready  = !s_valid;
            assign take_skid = out_xfer && s_valid;
            assign s_load    = in_xfer && id_valid && !out_xfer;
            assign s_clear   = flush || take_skid;

            assign m_load       = take_skid || (in_xfer && (!id_valid || out_xfer));
            assign m_clear      = flush || (out_xfer && !s_valid && !in_xfer);
            assign m_next_inst  = take_skid ? s_inst  : if_inst;
            assign m_next_pc_4  = take_skid ? s_pc_4  : if_pc_4;
            assign m_next_fault = take_skid ? s_fault : if_fault;

            pipe_entry_reg #(
                .ILEN     (ILEN),
                .XLEN     (XLEN),
                .NOP_INST (NOP_INST)
            ) u_skid (
                .clk        (clk),
                .rst        (rst),
                .load       (s_load),
                .clear      (s_clear),
                .next_inst  (if_inst),
                .next_pc_4  (if_pc_4),
                .next_fault (if_fault),
                .valid      (s_valid),
                .inst       (s_inst),
                .pc_4       (s_pc_4),
                .fault      (s_fault)
            );
        end else begin : g_single
            assign if_ready     = !id_valid || id_ready;
            assign m_load       = in_xfer;
            assign m_clear      = flush || (out_xfer && !in_xfer);
            assign m_next_inst  = if_inst;
            assign m_next_pc_4  = if_pc_4;
            assign m_next_fault = if_fault;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_valid && !id_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Bench for if_id_pipe_stage: skid, single-register and 4-bit-counter variants
// share one stimulus stream and are each compared with a queue-based model.
module tb_if_id_pipe_stage;
    import core_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc_4;
    logic        if_fault;
    logic        id_ready;

    logic        rdy_o   [3];
    logic        valid_o [3];
    logic [31:0] inst_o  [3];
    logic [31:0] pc_o    [3];
    logic        fault_o [3];
    logic [15:0] cnt_o   [3];
    logic [15:0] cnt_d1;
    logic [15:0] cnt_d0;
    logic [3:0]  cnt_d4;

    assign cnt_o[0] = cnt_d1;
    assign cnt_o[1] = cnt_d0;
    assign cnt_o[2] = {12'h000, cnt_d4};

    always #5 clk = ~clk;

    if_id_pipe_stage #(.NOP_INST(NOP), .SKID(1), .CNT_W(16)) d1 (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(rdy_o[0]),
        .if_inst(if_inst), .if_pc_4(if_pc_4), .if_fault(if_fault),
        .id_valid(valid_o[0]), .id_ready(id_ready), .id_inst(inst_o[0]),
        .id_pc_4(pc_o[0]), .id_fault(fault_o[0]), .stall_cnt(cnt_d1));

    if_id_pipe_stage #(.NOP_INST(NOP), .SKID(0), .CNT_W(16)) d0 (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(rdy_o[1]),
        .if_inst(if_inst), .if_pc_4(if_pc_4), .if_fault(if_fault),
        .id_valid(valid_o[1]), .id_ready(id_ready), .id_inst(inst_o[1]),
        .id_pc_4(pc_o[1]), .id_fault(fault_o[1]), .stall_cnt(cnt_d0));

    if_id_pipe_stage #(.NOP_INST(NOP), .SKID(1), .CNT_W(4)) d4 (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(rdy_o[2]),
        .if_inst(if_inst), .if_pc_4(if_pc_4), .if_fault(if_fault),
        .id_valid(valid_o[2]), .id_ready(id_ready), .id_inst(inst_o[2]),
        .id_pc_4(pc_o[2]), .id_fault(fault_o[2]), .stall_cnt(cnt_d4));

    // Model: each stage is a FIFO of capacity 2 (skid) or 1 (single register).
    if_id_entry_t mbuf [3][2];
    int           msz    [3];
    int           mstall [3];
    int           mcap   [3] = '{2, 1, 2};
    int           mmax   [3] = '{65535, 65535, 15};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d actual %h expected %h", name, idx, cyc, act, exp);
        end
    endtask

    function automatic logic mready(input int i);
        if (mcap[i] == 2) return msz[i] < 2;
        return (msz[i] == 0) || id_ready;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            msz[i]    = 0;
            mstall[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            logic        ev;
            logic [31:0] ei;
            logic [31:0] ep;
            logic        ef;
            ev = msz[i] > 0;
            ei = ev ? mbuf[i][0].inst : NOP;
            ep = ev ? mbuf[i][0].pc_4 : 32'h0;
            ef = ev ? mbuf[i][0].fault : 1'b0;
            chk("if_ready", i, {31'b0, rdy_o[i]}, {31'b0, mready(i)});
            chk("id_valid", i, {31'b0, valid_o[i]}, {31'b0, ev});
            chk("id_inst", i, inst_o[i], ei);
            chk("id_pc_4", i, pc_o[i], ep);
            chk("id_fault", i, {31'b0, fault_o[i]}, {31'b0, ef});
            chk("stall_cnt", i, {16'b0, cnt_o[i]}, mstall[i]);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            logic r;
            logic out_x;
            logic in_x;
            r = mready(i);
            if (msz[i] > 0 && !id_ready && !flush && mstall[i] < mmax[i]) mstall[i]++;
            if (flush) begin
                msz[i] = 0;
            end else begin
                out_x = (msz[i] > 0) && id_ready;
                in_x  = if_valid && r;
                if (out_x) begin
                    mbuf[i][0] = mbuf[i][1];
                    msz[i]--;
                end
                if (in_x) begin
                    mbuf[i][msz[i]] = '{inst: if_inst, pc_4: if_pc_4, fault: if_fault, valid: 1'b1};
                    msz[i]++;
                end
            end
        end
        cyc++;
    endtask

    // Inputs change at posedge+1; outputs are compared at the falling edge.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ev;
        logic [31:0] einst;
        logic [31:0] epc;
    } vec_t;

    vec_t tv [6];

    initial begin
        #1_000_000;
        $display("FAIL timeout actual running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        tv[0] = '{1'b1, 32'h2008_0001, 32'h0000_0004, 1'b0, NOP,          32'h0000_0000};
        tv[1] = '{1'b1, 32'h2008_0002, 32'h0000_0008, 1'b1, 32'h2008_0001, 32'h0000_0004};
        tv[2] = '{1'b1, 32'h2008_0003, 32'h0000_000C, 1'b1, 32'h2008_0002, 32'h0000_0008};
        tv[3] = '{1'b1, 32'h2008_0004, 32'h0000_0010, 1'b1, 32'h2008_0003, 32'h0000_000C};
        tv[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h2008_0004, 32'h0000_0010};
        tv[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, NOP,          32'h0000_0000};

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc_4 = '0;
        if_fault = 1'b0; id_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 0, {31'b0, valid_o[0]}, 32'h0);
        chk("rst_inst", 0, inst_o[0], NOP);
        chk("rst_pc_4", 0, pc_o[0], 32'h0);
        chk("rst_cnt", 0, {16'b0, cnt_o[0]}, 32'h0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk("rst_if_ready", i, {31'b0, rdy_o[i]}, 32'h1);

        // Streaming with ID always ready: one-cycle latency, back-to-back.
        id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if_valid = tv[k].iv; if_inst = tv[k].inst; if_pc_4 = tv[k].pc;
            #1;
            for (int i = 0; i < 2; i++) begin
                chk("tbl_valid", i, {31'b0, valid_o[i]}, {31'b0, tv[k].ev});
                chk("tbl_inst", i, inst_o[i], tv[k].einst);
                chk("tbl_pc_4", i, pc_o[i], tv[k].epc);
            end
            step();
        end

        // Skid: A held, B parked, IF throttled; then A and B drain in order.
        id_ready = 1'b0; if_valid = 1'b1; if_inst = 32'hAAAA_0001; if_pc_4 = 32'h100;
        step();
        if_inst = 32'hBBBB_0002; if_pc_4 = 32'h104;
        step();
        if_valid = 1'b0;
        step(); step();
        chk("skid_hold_inst", 0, inst_o[0], 32'hAAAA_0001);
        chk("skid_if_ready", 0, {31'b0, rdy_o[0]}, 32'h0);
        chk("skid_stall", 0, {16'b0, cnt_o[0]}, 32'd3);
        id_ready = 1'b1;
        step();
        chk("skid_second", 0, inst_o[0], 32'hBBBB_0002);
        chk("skid_pc_4", 0, pc_o[0], 32'h104);
        step();
        chk("skid_drained", 0, {31'b0, valid_o[0]}, 32'h0);

        // Flush with both entries full and a coincident input C.
        id_ready = 1'b0; if_valid = 1'b1; if_inst = 32'hA2A2_0001; if_pc_4 = 32'h200; if_fault = 1'b1;
        step();
        if_inst = 32'hB2B2_0002; if_pc_4 = 32'h204; if_fault = 1'b0;
        step();
        if_inst = 32'hC3C3_0003; if_pc_4 = 32'h208; flush = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0;
        chk("flush_valid", 0, {31'b0, valid_o[0]}, 32'h0);
        chk("flush_inst", 0, inst_o[0], NOP);
        chk("flush_pc_4", 0, pc_o[0], 32'h0);
        chk("flush_if_ready", 0, {31'b0, rdy_o[0]}, 32'h1);
        id_ready = 1'b1;
        repeat (3) begin
            step();
            chk("flush_no_c", 0, {31'b0, valid_o[0]}, 32'h0);
        end

        // Single register: if_ready follows id_ready combinationally.
        id_ready = 1'b0; if_valid = 1'b1; if_inst = 32'hDDDD_0004; if_pc_4 = 32'h300;
        step();
        if_valid = 1'b0;
        #1;
        chk("comb_ready_lo", 1, {31'b0, rdy_o[1]}, 32'h0);
        id_ready = 1'b1;
        #1;
        chk("comb_ready_hi", 1, {31'b0, rdy_o[1]}, 32'h1);
        if_valid = 1'b1; if_inst = 32'hEEEE_0005; if_pc_4 = 32'h304;
        step();
        chk("swap_inst", 1, inst_o[1], 32'hEEEE_0005);
        chk("swap_valid", 1, {31'b0, valid_o[1]}, 32'h1);
        if_valid = 1'b0;
        step();

        // Asynchronous reset mid-stream with the skid full.
        id_ready = 1'b0; if_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if_inst = 32'h5000_0000 + k; if_pc_4 = 32'h400 + 4 * k;
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 0, {31'b0, valid_o[0]}, 32'h0);
        chk("arst_inst", 0, inst_o[0], NOP);
        chk("arst_cnt", 0, {16'b0, cnt_o[0]}, 32'h0);
        chk("arst_cnt", 1, {16'b0, cnt_o[1]}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; if_valid = 1'b0;
        #1;
        chk("arst_if_ready", 0, {31'b0, rdy_o[0]}, 32'h1);

        // Stall counter saturation: 2^4+5 stall cycles.
        id_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h6000_0001; if_pc_4 = 32'h500;
        step();
        if_valid = 1'b0;
        repeat (21) step();
        chk("sat_cnt4", 2, {16'b0, cnt_o[2]}, 32'd15);
        chk("sat_cnt16", 0, {16'b0, cnt_o[0]}, 32'd21);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            id_ready = (n % 80 < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            if_inst  = $urandom;
            if_pc_4  = $urandom;
            if_fault = $urandom_range(0, 1) == 1;
            step();
        end
        flush = 1'b0; if_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
